// File: rtl/sc_fifo_ext.sv
// Single-clock FIFO with registered status flags, flush and overflow/underflow pulses.
// Latency: a write is visible one cycle later (show-ahead); registered mode returns data one cycle after the read.
// Backpressure: writes while full and reads while empty are dropped and flagged with a one-cycle error pulse.
module sc_fifo_ext #(
  parameter int DATA_WIDTH   = 8,
  parameter int WORDS_AMOUNT = 16,
  parameter int SHOWAHEAD    = 1,
  parameter int AFULL_LVL    = WORDS_AMOUNT - 2,
  parameter int AEMPTY_LVL   = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                wr_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  input  logic                                rd_i,
  output logic [DATA_WIDTH-1:0]               rd_data_o,
  output logic [$clog2(WORDS_AMOUNT):0]       used_words_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic                                almost_full_o,
  output logic                                almost_empty_o,
  output logic                                ovf_o,
  output logic                                udf_o
);

  localparam int ADDR_WIDTH = $clog2(WORDS_AMOUNT);

  // Pointers wrap at the real depth, not at the next power of two.
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(WORDS_AMOUNT - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(WORDS_AMOUNT);

  logic [DATA_WIDTH-1:0] mem [WORDS_AMOUNT];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses this cycle's registered flags; flush cancels both requests.
  assign wr_acc = wr_i & ~full_q  & ~flush_i;
  assign rd_acc = rd_i & ~empty_q & ~flush_i;

  // Next-state pointers, count, flags and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = wr_i & full_q  & ~flush_i;
    udf_d    = rd_i & empty_q & ~flush_i;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
        default: count_d = count_q;
      endcase
    end

    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    afull_d  = (int'(count_d) >= AFULL_LVL);
    aempty_d = (int'(count_d) <= AEMPTY_LVL);
  end

  // Control state register; reset dominates flush and all requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_LVL <= 0);
      aempty_q <= (AEMPTY_LVL >= 0);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Oldest word is presented directly; masked to zero while nothing valid is stored.
      assign rd_data_o = empty_q ? '0 : mem[rd_ptr_q];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;

      // Capture the oldest word on an accepted read and hold it otherwise.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_data_q <= '0;
        end else if (rd_acc) begin
          rd_data_q <= mem[rd_ptr_q];
        end
      end

      assign rd_data_o = rd_data_q;
    end
  endgenerate

  assign used_words_o   = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;

endmodule

// File: doc/sc_fifo_ext.md
SC_FIFO_EXT -- requirements
Module: sc_fifo_ext

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 The block SHALL have parameter WORDS_AMOUNT, default 16, depth in words (>=2, power of two not required).
REQ-003 The block SHALL have parameter SHOWAHEAD, default 1: 1 = first-word-fall-through, 0 = registered read.
REQ-004 The block SHALL have parameter AFULL_LVL, default WORDS_AMOUNT-2, almost-full threshold in words.
REQ-005 The block SHALL have parameter AEMPTY_LVL, default 2, almost-empty threshold in words.
REQ-006 The block SHALL derive ADDR_WIDTH = $clog2(WORDS_AMOUNT) internally; it SHALL NOT be user-set.
REQ-007 The block SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-009 The block SHALL have port flush_i  input  1  synchronous clear of contents.
REQ-010 The block SHALL have port wr_i  input  1  write request.
REQ-011 The block SHALL have port wr_data_i  input  DATA_WIDTH  write data.
REQ-012 The block SHALL have port rd_i  input  1  read request.
REQ-013 The block SHALL have port rd_data_o  output  DATA_WIDTH  read data.
REQ-014 The block SHALL have port used_words_o  output  ADDR_WIDTH+1  stored word count.
REQ-015 The block SHALL have ports full_o, empty_o, almost_full_o, almost_empty_o  output  1  registered status flags.
REQ-016 The block SHALL have ports ovf_o, udf_o  output  1  one-cycle overflow/underflow error pulses.

Function
REQ-017 A write SHALL be accepted iff wr_i=1 and full_o=0; wr_i=1 with full_o=1 SHALL discard the data and pulse ovf_o next cycle.
REQ-018 A read SHALL be accepted iff rd_i=1 and empty_o=0; rd_i=1 with empty_o=1 SHALL pulse udf_o next cycle with no state change.
REQ-019 Acceptance SHALL use flag values of the current cycle: write when full is rejected even with a simultaneous accepted read; read when empty is rejected even with a simultaneous accepted write.
REQ-020 Accepted write+read in one cycle SHALL leave used_words_o unchanged; write only +1, read only -1, next cycle.
REQ-021 Write and read pointers SHALL wrap from WORDS_AMOUNT-1 to 0 (modulo WORDS_AMOUNT, not 2**ADDR_WIDTH).
REQ-022 full_o SHALL equal (used_words_o == WORDS_AMOUNT) and empty_o (used_words_o == 0), updated the same cycle as the count.
REQ-023 almost_full_o SHALL equal (used_words_o >= AFULL_LVL); almost_empty_o SHALL equal (used_words_o <= AEMPTY_LVL).
REQ-024 SHOWAHEAD=1: while empty_o=0 rd_data_o SHALL present the oldest word; after an accepted read the next word SHALL appear next cycle; a write into an empty FIFO SHALL be visible with empty_o=0 one cycle after the write.
REQ-025 SHOWAHEAD=0: rd_data_o SHALL update with the oldest word one cycle after an accepted read and hold otherwise.
REQ-026 flush_i=1 SHALL zero pointers and count next cycle, overriding wr_i/rd_i that cycle; those requests SHALL be discarded without ovf_o/udf_o.
REQ-027 ovf_o and udf_o SHALL be single-cycle pulses, one per rejected request, no stickiness.

Reset
REQ-028 rst_i=1 SHALL have priority over flush_i, wr_i and rd_i.
REQ-029 After reset: used_words_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AFULL_LVL==0), ovf_o=0, udf_o=0, rd_data_o=0.
REQ-030 Storage array contents SHALL NOT be reset; reset mid-operation SHALL discard all stored words.

Verification (DATA_WIDTH=8, WORDS_AMOUNT=5, AFULL_LVL=4, AEMPTY_LVL=1, SHOWAHEAD=1 unless stated)
REQ-031 Write 0x11,0x22,0x33,0x44,0x55 -> almost_empty_o low at count 2, almost_full_o high at 4, full_o at 5; 6th write 0x66 -> ovf_o one cycle, count stays 5.
REQ-032 From full, read 5 -> rd_data_o 0x11 before first rd_i, then 0x22..0x55, empty_o after 5th; 6th read -> udf_o one cycle.
REQ-033 Full + simultaneous wr/rd -> read accepted, write rejected, ovf_o, count 4; empty + simultaneous wr/rd -> write accepted, udf_o, count 1.
REQ-034 3 words stored, flush_i with wr_i=1 -> next cycle count 0, empty_o=1, no ovf_o; subsequent write 0xA5 read back as 0xA5.
REQ-035 SHOWAHEAD=0, write 0x3C, read -> rd_data_o=0x3C exactly one cycle after accepted read.
REQ-036 1e6 random 50/50 wr/rd cycles with queue reference model -> no data mismatch, count matches queue size every cycle across pointer wrap.
